iccm_loader_tlul: RTL and testbench

- Boot-time programmer that sits directly upstream of the instruction memory.
- Takes a byte stream (UART RX or similar) and packs the bytes little-endian into 32-bit words.
- Writes each word into instruction memory as a TL-UL PutFullData on its host port.
- Holds the core in reset until loading finishes. Loading ends on a terminator word, on reaching the word limit, or on a bus error.

---
 rtl/iccm_loader_tlul.sv | 229 ++++++++++++++++++++++
 tb/tb_iccm_loader_tlul.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iccm_loader_tlul.sv
// Boot loader: packs a byte stream little-endian into 32-bit words and writes them
// to instruction memory over TL-UL. Optional readback verify: ICCM_LOADER_READBACK_EN.

package tlul_pkg;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic [4:0] rsvd;
        logic [3:0] instr_type;
        logic [6:0] cmd_intg;
        logic [6:0] data_intg;
    } tl_a_user_t;

    typedef struct packed {
        logic [6:0] rsp_intg;
        logic [6:0] data_intg;
    } tl_d_user_t;

    typedef struct packed {
        logic       a_valid;
        tl_a_op_e   a_opcode;
        logic [2:0] a_param;
        logic [1:0] a_size;
        logic [7:0] a_source;
        logic [31:0] a_address;
        logic [3:0] a_mask;
        logic [31:0] a_data;
        tl_a_user_t a_user;
        logic       d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic       d_valid;
        tl_d_op_e   d_opcode;
        logic [2:0] d_param;
        logic [1:0] d_size;
        logic [7:0] d_source;
        logic [0:0] d_sink;
        logic [31:0] d_data;
        tl_d_user_t d_user;
        logic       d_error;
        logic       a_ready;
    } tl_d2h_t;

endpackage

module iccm_loader_tlul #(
    parameter logic [31:0] BaseAddr = 32'h0000_0000,
    parameter int unsigned MaxWords = 1024,
    parameter logic [31:0] EndWord  = 32'h0000_0FFF,
    localparam int unsigned CntW    = $clog2(MaxWords) + 1
) (
    input  logic                clock,
    input  logic                rst_ni,
    input  logic                rx_valid_i,
    input  logic [7:0]          rx_byte_i,
    output logic                rx_ready_o,
    output tlul_pkg::tl_h2d_t   tl_o,
    input  tlul_pkg::tl_d2h_t   tl_i,
    output logic [CntW-1:0]     words_o,
    output logic                load_done_o,
    output logic                load_err_o,
    output logic                core_rst_no
);

    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxWords);

    typedef enum logic [2:0] {
        COLLECT = 3'd0,
        REQ     = 3'd1,
        RESP    = 3'd2,
`ifdef ICCM_LOADER_READBACK_EN
        RD_REQ  = 3'd4,
        RD_RESP = 3'd5,
`endif
        DONE    = 3'd3
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [31:0]     word_q, word_d;
    logic [CntW-1:0] words_q, words_d;
    logic            err_q, err_d;

    logic [CntW-1:0] words_inc;
    logic [31:0]     req_addr;

    assign words_inc = words_q + 1'b1;
    // Word-aligned address of the next slot to fill.
    assign req_addr  = BaseAddr + {{(30-CntW){1'b0}}, words_q, 2'b00};

    always_ff @(posedge clock or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= COLLECT;
            idx_q   <= 2'd0;
            word_q  <= 32'd0;
            words_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            words_q <= words_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        words_d = words_q;
        err_d   = err_q;
        unique case (state_q)
            COLLECT: begin
                if (rx_valid_i) begin
                    word_d[8*idx_q +: 8] = rx_byte_i;
                    idx_d                = idx_q + 2'd1;
                    // The terminator check must see the byte arriving this cycle.
                    if (idx_q == 2'd3) begin
                        state_d = (word_d == EndWord) ? DONE : REQ;
                    end
                end
            end
            REQ: begin
                if (tl_i.a_ready) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (tl_i.d_valid) begin
                    if (tl_i.d_error) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
`ifdef ICCM_LOADER_READBACK_EN
                        state_d = RD_REQ;
`else
                        words_d = words_inc;
                        state_d = (words_inc == MaxCnt) ? DONE : COLLECT;
`endif
                    end
                end
            end
`ifdef ICCM_LOADER_READBACK_EN
            RD_REQ: begin
                if (tl_i.a_ready) begin
                    state_d = RD_RESP;
                end
            end
            RD_RESP: begin
                // Only a word that reads back intact counts as loaded.
                if (tl_i.d_valid) begin
                    if (tl_i.d_error || (tl_i.d_data != word_q)) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        words_d = words_inc;
                        state_d = (words_inc == MaxCnt) ? DONE : COLLECT;
                    end
                end
            end
`endif
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    always_comb begin
        tl_o       = '0;
        rx_ready_o = (state_q == COLLECT);
        unique case (state_q)
            REQ: begin
                tl_o.a_valid   = 1'b1;
                tl_o.a_opcode  = tlul_pkg::PutFullData;
                tl_o.a_size    = 2'd2;
                tl_o.a_mask    = 4'hF;
                tl_o.a_address = req_addr;
                tl_o.a_data    = word_q;
            end
`ifdef ICCM_LOADER_READBACK_EN
            RD_REQ: begin
                tl_o.a_valid   = 1'b1;
                tl_o.a_opcode  = tlul_pkg::Get;
                tl_o.a_size    = 2'd2;
                tl_o.a_mask    = 4'hF;
                tl_o.a_address = req_addr;
            end
            RD_RESP: begin
                tl_o.d_ready = 1'b1;
            end
`endif
            RESP: begin
                tl_o.d_ready = 1'b1;
            end
            // Keep accepting responses once finished so a stray one cannot stall the bus.
            DONE: begin
                tl_o.d_ready = 1'b1;
            end
            default: begin
                tl_o.d_ready = 1'b0;
            end
        endcase
    end

    assign words_o     = words_q;
    assign load_done_o = (state_q == DONE);
    assign load_err_o  = err_q;
    assign core_rst_no = (state_q == DONE) && !err_q;

    logic unused_tl;
    assign unused_tl = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size, tl_i.d_source,
                         tl_i.d_sink, tl_i.d_user, tl_i.d_data};

endmodule

// File: tb/tb_iccm_loader_tlul.sv
// Scoreboard bench for iccm_loader_tlul: a reference model predicts the TL-UL
// requests of each image, a memory responder pops and checks them as they appear.

module tb_iccm_loader_tlul;
    import tlul_pkg::*;

    localparam logic [31:0] BaseAddr = 32'h0000_0000;
    localparam int          MaxWords = 4;
    localparam logic [31:0] EndWord  = 32'h0000_0FFF;
    localparam int          CntW     = $clog2(MaxWords) + 1;

    logic            clock = 1'b0;
    logic            rst_ni = 1'b0;
    logic            rx_valid_i = 1'b0;
    logic [7:0]      rx_byte_i = 8'd0;
    logic            rx_ready_o;
    tl_h2d_t         tl_o;
    tl_d2h_t         tl_i;
    logic [CntW-1:0] words_o;
    logic            load_done_o;
    logic            load_err_o;
    logic            core_rst_no;

    iccm_loader_tlul #(
        .BaseAddr (BaseAddr),
        .MaxWords (MaxWords),
        .EndWord  (EndWord)
    ) dut (
        .clock       (clock),
        .rst_ni      (rst_ni),
        .rx_valid_i  (rx_valid_i),
        .rx_byte_i   (rx_byte_i),
        .rx_ready_o  (rx_ready_o),
        .tl_o        (tl_o),
        .tl_i        (tl_i),
        .words_o     (words_o),
        .load_done_o (load_done_o),
        .load_err_o  (load_err_o),
        .core_rst_no (core_rst_no)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        is_get;
        logic [31:0] addr;
        logic [31:0] data;
        logic        resp_err;
        logic        resp_bad;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] img[$];
    logic [31:0] mem[logic [31:0]];

    int n_checks    = 0;
    int n_errors    = 0;
    int ready_delay = -1;
    int resp_lat    = -1;
    int bytes_acc   = 0;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic do_reset();
        rst_ni     = 1'b0;
        rx_valid_i = 1'b0;
        repeat (2) @(negedge clock);
        rst_ni = 1'b1;
        @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ok);
        int c;
        bit quit;
        ok         = 1'b0;
        quit       = 1'b0;
        c          = 0;
        rx_valid_i = 1'b1;
        rx_byte_i  = b;
        while (!quit) begin
            if (rx_ready_o) begin
                ok = 1'b1;
                bytes_acc++;
                quit = 1'b1;
            end else if (load_done_o || c >= 300) begin
                quit = 1'b1;
            end
            @(negedge clock);
            c++;
        end
        rx_valid_i = 1'b0;
    endtask

    // Memory responder and monitor: pops the predicted request when the DUT raises a_valid.
    initial begin : responder
        bit          in_a;
        int          hold;
        exp_t        cur;
        exp_t        rsp;
        bit          rsp_pend;
        int          rsp_cnt;
        logic [2:0]  exp_op;
        in_a     = 1'b0;
        hold     = 0;
        rsp_pend = 1'b0;
        rsp_cnt  = 0;
        cur      = '{is_get: 1'b0, addr: 32'd0, data: 32'd0, resp_err: 1'b0, resp_bad: 1'b0};
        rsp      = cur;
        tl_i     = '0;
        forever begin
            @(negedge clock);
            if (!rst_ni) begin
                tl_i     = '0;
                in_a     = 1'b0;
                rsp_pend = 1'b0;
                continue;
            end
            tl_i.d_valid  = 1'b0;
            tl_i.d_error  = 1'b0;
            tl_i.d_data   = 32'd0;
            tl_i.d_opcode = AccessAck;
            if (rsp_pend) begin
                if (rsp_cnt > 0) begin
                    rsp_cnt--;
                end else if (tl_o.d_ready) begin
                    tl_i.d_valid = 1'b1;
                    tl_i.d_error = rsp.resp_err;
                    if (rsp.is_get) begin
                        tl_i.d_opcode = AccessAckData;
                        if (rsp.resp_bad) tl_i.d_data = 32'hDEAD_BEEF;
                        else if (mem.exists(rsp.addr)) tl_i.d_data = mem[rsp.addr];
                    end
                    rsp_pend = 1'b0;
                end
            end
            tl_i.a_ready = 1'b0;
            if (tl_o.a_valid) begin
                if (!in_a) begin
                    check_output("req_expected", 64'(sb_q.size() != 0), 64'd1);
                    if (sb_q.size() != 0) cur = sb_q.pop_front();
                    in_a = 1'b1;
                    hold = (ready_delay >= 0) ? ready_delay : int'($urandom_range(0, 3));
                end
                exp_op = cur.is_get ? 3'h4 : 3'h0;
                check_output("a_address", 64'(tl_o.a_address), 64'(cur.addr));
                if (!cur.is_get) check_output("a_data", 64'(tl_o.a_data), 64'(cur.data));
                check_output("a_attr",
                             64'({tl_o.a_opcode, tl_o.a_param, tl_o.a_size, tl_o.a_mask,
                                  tl_o.a_source, tl_o.a_user}),
                             64'({exp_op, 3'd0, 2'd2, 4'hF, 8'd0, 23'd0}));
                check_output("rx_ready_in_req", 64'(rx_ready_o), 64'd0);
                if (hold == 0) begin
                    tl_i.a_ready = 1'b1;
                    in_a         = 1'b0;
                    if (!cur.is_get) mem[cur.addr] = tl_o.a_data;
                    rsp      = cur;
                    rsp_pend = 1'b1;
                    rsp_cnt  = ((resp_lat >= 1) ? resp_lat : int'($urandom_range(1, 3))) - 1;
                end else begin
                    hold--;
                end
            end
        end
    end

    // Reference model: walks the image by the loader's rules, queues the expected
    // requests, then streams the bytes and checks the final status.
    task automatic apply_stimulus(input int err_idx, input int bad_idx, input int rdy, input int lat);
        int          n_written;
        int          consumed;
        bit          stop;
        bit          exp_err;
        bit          halt;
        bit          ok;
        logic [31:0] w;
        n_written   = 0;
        consumed    = 0;
        stop        = 1'b0;
        exp_err     = 1'b0;
        ready_delay = rdy;
        resp_lat    = lat;
        do_reset();
        bytes_acc = 0;
        foreach (img[k]) begin
            if (stop) break;
            consumed++;
            if (img[k] == EndWord) begin
                stop = 1'b1;
            end else begin
                sb_q.push_back('{is_get: 1'b0, addr: BaseAddr + 32'(4 * n_written), data: img[k],
                                 resp_err: (k == err_idx), resp_bad: 1'b0});
                if (k == err_idx) begin
                    exp_err = 1'b1;
                    stop    = 1'b1;
                end else begin
`ifdef ICCM_LOADER_READBACK_EN
                    sb_q.push_back('{is_get: 1'b1, addr: BaseAddr + 32'(4 * n_written), data: img[k],
                                     resp_err: 1'b0, resp_bad: (k == bad_idx)});
                    if (k == bad_idx) begin
                        exp_err = 1'b1;
                        stop    = 1'b1;
                    end
`endif
                    if (!stop) begin
                        n_written++;
                        if (n_written == MaxWords) stop = 1'b1;
                    end
                end
            end
        end
        halt = 1'b0;
        for (int k = 0; k < img.size() && !halt; k++) begin
            w = img[k];
            for (int b = 0; b < 4 && !halt; b++) begin
                if (load_done_o) begin
                    halt = 1'b1;
                end else begin
                    send_byte(w[8*b +: 8], ok);
                    if (!ok) halt = 1'b1;
                end
            end
        end
        for (int c = 0; c < 200 && !load_done_o; c++) @(negedge clock);
        repeat (2) @(negedge clock);
        check_output("load_done", 64'(load_done_o), 64'd1);
        check_output("load_err", 64'(load_err_o), 64'(exp_err));
        check_output("words", 64'(words_o), 64'(n_written));
        check_output("core_rst_n", 64'(core_rst_no), 64'(!exp_err));
        check_output("rx_ready_done", 64'(rx_ready_o), 64'd0);
        check_output("a_valid_done", 64'(tl_o.a_valid), 64'd0);
        check_output("bytes_accepted", 64'(bytes_acc), 64'(4 * consumed));
        check_output("sb_drained", 64'(sb_q.size()), 64'd0);
        sb_q.delete();
    endtask

    task automatic reset_mid_test();
        bit          ok;
        logic [31:0] w;
        w = $urandom();
        if (w == EndWord) w = w ^ 32'd1;
        ready_delay = 0;
        resp_lat    = 1000;
        do_reset();
        bytes_acc = 0;
        sb_q.push_back('{is_get: 1'b0, addr: BaseAddr, data: w, resp_err: 1'b0, resp_bad: 1'b0});
        for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], ok);
        for (int c = 0; c < 50 && !tl_o.d_ready; c++) @(negedge clock);
        check_output("in_resp", 64'(tl_o.d_ready), 64'd1);
        rx_valid_i = 1'b1;
        rx_byte_i  = 8'hA5;
        repeat (2) @(negedge clock);
        rx_byte_i = 8'h5A;
        repeat (2) @(negedge clock);
        check_output("resp_backpressure", 64'(rx_ready_o), 64'd0);
        check_output("resp_bytes", 64'(bytes_acc), 64'd4);
        rst_ni = 1'b0;
        #1;
        check_output("mid_rst_words", 64'(words_o), 64'd0);
        check_output("mid_rst_done", 64'(load_done_o), 64'd0);
        check_output("mid_rst_err", 64'(load_err_o), 64'd0);
        check_output("mid_rst_core", 64'(core_rst_no), 64'd0);
        check_output("mid_rst_avalid", 64'(tl_o.a_valid), 64'd0);
        check_output("mid_rst_dready", 64'(tl_o.d_ready), 64'd0);
        rx_valid_i = 1'b0;
        check_output("mid_rst_sb", 64'(sb_q.size()), 64'd0);
        sb_q.delete();
        @(negedge clock);
    endtask

    initial begin : stimulus
        logic [31:0] w;
        int          n;
        int          e;
        int          bad;
        tl_i = '0;
        #1;
        check_output("rst_words", 64'(words_o), 64'd0);
        check_output("rst_done", 64'(load_done_o), 64'd0);
        check_output("rst_err", 64'(load_err_o), 64'd0);
        check_output("rst_core", 64'(core_rst_no), 64'd0);
        check_output("rst_avalid", 64'(tl_o.a_valid), 64'd0);
        check_output("rst_dready", 64'(tl_o.d_ready), 64'd0);

        $display("[TB] single word then terminator");
        img = {32'h0000_0513, EndWord};
        apply_stimulus(-1, -1, -1, -1);

        $display("[TB] a_ready held low for 5 cycles");
        w = $urandom();
        if (w == EndWord) w = w ^ 32'd1;
        img = {w, EndWord};
        apply_stimulus(-1, -1, 5, 2);

        $display("[TB] word limit reached");
        img.delete();
        for (int i = 0; i < 5; i++) begin
            w = $urandom();
            if (w == EndWord) w = w ^ 32'd1;
            img.push_back(w);
        end
        apply_stimulus(-1, -1, -1, -1);

        $display("[TB] error response on second write");
        img = {32'h1111_2222, 32'h3333_4444, 32'h5555_6666, EndWord};
        apply_stimulus(1, -1, 1, 1);

        $display("[TB] reset while waiting for a response");
        reset_mid_test();
        img = {32'h0000_0513, 32'h00A0_0093, EndWord};
        apply_stimulus(-1, -1, 0, 1);

`ifdef ICCM_LOADER_READBACK_EN
        $display("[TB] readback returns wrong data");
        img = {32'h0000_0513, EndWord};
        apply_stimulus(-1, 0, 0, 1);
`endif

        $display("[TB] randomized images");
        for (int t = 0; t < 12; t++) begin
            img.delete();
            n = $urandom_range(0, 5);
            for (int i = 0; i < n; i++) begin
                w = $urandom();
                if (w == EndWord) w = w ^ 32'd1;
                img.push_back(w);
            end
            img.push_back(EndWord);
            e   = ($urandom_range(0, 1) == 1 && n > 0) ? int'($urandom_range(0, n - 1)) : -1;
            bad = ($urandom_range(0, 2) == 0 && n > 0) ? int'($urandom_range(0, n - 1)) : -1;
            apply_stimulus(e, bad, -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
